// File: rtl/arm_lp_pkg.sv
// Shared definitions for the ARM-LP multi-cycle sequencer: state encodings,
// default halt opcode and the sequential PC step.
package arm_lp_pkg;

    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_FETCH     = 3'd1;
    localparam logic [2:0] STATE_DECODE    = 3'd2;
    localparam logic [2:0] STATE_EXECUTE   = 3'd3;
    localparam logic [2:0] STATE_MEMORY    = 3'd4;
    localparam logic [2:0] STATE_WRITEBACK = 3'd5;
    localparam logic [2:0] STATE_HALT      = 3'd6;
    localparam logic [2:0] STATE_ERROR     = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = STATE_IDLE,
        FETCH     = STATE_FETCH,
        DECODE    = STATE_DECODE,
        EXECUTE   = STATE_EXECUTE,
        MEMORY    = STATE_MEMORY,
        WRITEBACK = STATE_WRITEBACK,
        HALT      = STATE_HALT,
        ERROR     = STATE_ERROR
    } seqState_e;

    localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned PC_INCREMENT        = 4;
    localparam int unsigned WAIT_WIDTH          = 8;

    // Controller/ALU flags captured in EXECUTE for the rest of the instruction
    typedef struct packed {
        logic memWrite;
        logic regWrite;
        logic branch;
        logic uncondBranch;
        logic zero;
    } execFlags_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter shared by FETCH and MEMORY; flags the last
// permitted wait cycle before a bus timeout.
module mem_wait_timer
    import arm_lp_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic timeout_c
);

    logic [WAIT_WIDTH-1:0] waitCount;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            waitCount <= '0;
        end else if (clear) begin
            waitCount <= '0;
        end else if (enable) begin
            waitCount <= waitCount + WAIT_WIDTH'(1);
        end
    end

    // High on the cycle whose missing ready would be the MEM_TIMEOUT-th miss
    assign timeout_c = (waitCount == WAIT_WIDTH'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer owning the PC
// and instruction register, with ready handshakes, timeout, halt and retire count.
module multicycle_sequencer
    import arm_lp_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH   = 32,
    parameter int unsigned             INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int unsigned             MEM_TIMEOUT  = 15,
    parameter logic [INSTR_WIDTH-1:0]  HALT_OPCODE  = INSTR_WIDTH'(HALT_OPCODE_DEFAULT),
    parameter int unsigned             COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   run,
    input  logic                   instrReady,
    input  logic [INSTR_WIDTH-1:0] instrData,
    input  logic                   dataReady,
    input  logic                   memReadFlag,
    input  logic                   memWriteFlag,
    input  logic                   regWriteFlag,
    input  logic                   branchFlag,
    input  logic                   unconditionalBranchFlag,
    input  logic                   zeroFlag,
    input  logic [ADDR_WIDTH-1:0]  pcOffset,
    output logic [ADDR_WIDTH-1:0]  pcOut,
    output logic [INSTR_WIDTH-1:0] irOut,
    output logic                   instrReq,
    output logic                   dataReq,
    output logic                   dataWrite,
    output logic                   aluEnable,
    output logic                   regWriteEnable,
    output logic [2:0]             stateOut,
    output logic                   halted,
    output logic                   busError,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    seqState_e             state;
    seqState_e             stateNext;
    execFlags_t            flagsLive;
    execFlags_t            flagsReg;
    execFlags_t            flagsUse;
    logic [ADDR_WIDTH-1:0] offsetReg;
    logic [ADDR_WIDTH-1:0] offsetUse;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic                  branchTaken;
    logic                  retire;
    logic                  waitClear;
    logic                  waitEnable;
    logic                  timeout_c;

    assign flagsLive = '{memWrite:     memWriteFlag,
                         regWrite:     regWriteFlag,
                         branch:       branchFlag,
                         uncondBranch: unconditionalBranchFlag,
                         zero:         zeroFlag};

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_waitTimer (
        .clock     (clock),
        .resetN    (resetN),
        .clear     (waitClear),
        .enable    (waitEnable),
        .timeout_c (timeout_c)
    );

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, retire and wait-timer control
    always_comb begin
        stateNext  = state;
        retire     = 1'b0;
        waitClear  = 1'b1;
        waitEnable = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) stateNext = FETCH;
            end
            FETCH: begin
                waitClear  = instrReady;
                waitEnable = !instrReady;
                if (instrReady)     stateNext = DECODE;
                else if (timeout_c) stateNext = ERROR;
            end
            DECODE: begin
                stateNext = (irOut == HALT_OPCODE) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (memReadFlag || memWriteFlag) stateNext = MEMORY;
                else if (regWriteFlag)           stateNext = WRITEBACK;
                else                             retire    = 1'b1;
            end
            MEMORY: begin
                waitClear  = dataReady;
                waitEnable = !dataReady;
                if (dataReady) begin
                    if (flagsReg.regWrite) stateNext = WRITEBACK;
                    else                   retire    = 1'b1;
                end else if (timeout_c) begin
                    stateNext = ERROR;
                end
            end
            WRITEBACK: begin
                retire = 1'b1;
            end
            HALT, ERROR: begin
                stateNext = state;
            end
        endcase
        if (retire) stateNext = run ? FETCH : IDLE;
    end

    // Flags are live in EXECUTE (the capture cycle) and held afterwards
    always_comb begin
        flagsUse    = (state == EXECUTE) ? flagsLive : flagsReg;
        offsetUse   = (state == EXECUTE) ? pcOffset : offsetReg;
        branchTaken = flagsUse.uncondBranch | (flagsUse.branch & flagsUse.zero);
        pcNext      = pcOut + (branchTaken ? (offsetUse << 2)
                                           : ADDR_WIDTH'(PC_INCREMENT));
    end

    // PC, instruction register, captured flags and retire counter
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pcOut        <= RESET_VECTOR;
            irOut        <= '0;
            flagsReg     <= '0;
            offsetReg    <= '0;
            retiredCount <= '0;
        end else begin
            if (state == FETCH && instrReady) irOut <= instrData;
            if (state == EXECUTE) begin
                flagsReg  <= flagsLive;
                offsetReg <= pcOffset;
            end
            if (retire) begin
                pcOut <= pcNext;
                if (retiredCount != '1) retiredCount <= retiredCount + COUNT_WIDTH'(1);
            end
        end
    end

    // Strobes registered from the next state so they track state exactly
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            instrReq       <= 1'b0;
            dataReq        <= 1'b0;
            dataWrite      <= 1'b0;
            aluEnable      <= 1'b0;
            regWriteEnable <= 1'b0;
            halted         <= 1'b0;
            busError       <= 1'b0;
        end else begin
            instrReq       <= (stateNext == FETCH);
            dataReq        <= (stateNext == MEMORY);
            dataWrite      <= (stateNext == MEMORY) && flagsUse.memWrite;
            aluEnable      <= (stateNext == EXECUTE);
            regWriteEnable <= (stateNext == WRITEBACK);
            halted         <= (stateNext == HALT);
            busError       <= (stateNext == ERROR);
        end
    end

    assign stateOut = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed and randomized
// instructions compared against an instruction-level phase/PC model.
module tb_multicycle_sequencer;

    localparam logic [31:0] HALT_OP = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        resetN;
    logic        run;
    logic        instrReady;
    logic [31:0] instrData;
    logic        dataReady;
    logic        memReadFlag, memWriteFlag, regWriteFlag;
    logic        branchFlag, unconditionalBranchFlag, zeroFlag;
    logic [31:0] pcOffset;
    logic [31:0] pcOut;
    logic [31:0] irOut;
    logic        instrReq, dataReq, dataWrite, aluEnable, regWriteEnable;
    logic [2:0]  stateOut;
    logic        halted, busError;
    logic [1:0]  retiredCount;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] modelPc;
    logic [1:0]  modelCnt;

    multicycle_sequencer #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_VECTOR(32'h0),
        .MEM_TIMEOUT(15), .HALT_OPCODE(HALT_OP), .COUNT_WIDTH(2)
    ) dut (
        .clock(clock), .resetN(resetN), .run(run),
        .instrReady(instrReady), .instrData(instrData), .dataReady(dataReady),
        .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag), .regWriteFlag(regWriteFlag),
        .branchFlag(branchFlag), .unconditionalBranchFlag(unconditionalBranchFlag),
        .zeroFlag(zeroFlag), .pcOffset(pcOffset),
        .pcOut(pcOut), .irOut(irOut), .instrReq(instrReq), .dataReq(dataReq),
        .dataWrite(dataWrite), .aluEnable(aluEnable), .regWriteEnable(regWriteEnable),
        .stateOut(stateOut), .halted(halted), .busError(busError),
        .retiredCount(retiredCount)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {instrReq,dataReq,dataWrite,aluEnable,regWriteEnable,halted,busError} per phase
    function automatic logic [6:0] expStrobes(input logic [2:0] st, input logic wr);
        case (st)
            3'd1:    return 7'b100_0000;
            3'd3:    return 7'b000_1000;
            3'd4:    return {2'b01, wr, 4'b0000};
            3'd5:    return 7'b000_0100;
            3'd6:    return 7'b000_0010;
            3'd7:    return 7'b000_0001;
            default: return 7'b000_0000;
        endcase
    endfunction

    task automatic checkCycle(input string tag, input logic [2:0] st, input logic wr);
        checkVal({tag, ".state"}, 64'(stateOut), 64'(st));
        checkVal({tag, ".strobes"},
                 64'({instrReq, dataReq, dataWrite, aluEnable, regWriteEnable, halted, busError}),
                 64'(expStrobes(st, wr)));
    endtask

    task automatic clearInputs();
        instrReady = 0; instrData = '0; dataReady = 0;
        memReadFlag = 0; memWriteFlag = 0; regWriteFlag = 0;
        branchFlag = 0; unconditionalBranchFlag = 0; zeroFlag = 0; pcOffset = '0;
    endtask

    // Called at a negedge; reset is checked asynchronously, before any clock edge
    task automatic doReset();
        resetN = 0;
        run = 0;
        clearInputs();
        #1;
        checkCycle("reset", 3'd0, 1'b0);
        checkVal("reset.pc", 64'(pcOut), 64'h0);
        checkVal("reset.ir", 64'(irOut), 64'h0);
        checkVal("reset.count", 64'(retiredCount), 64'h0);
        modelPc = 32'h0;
        modelCnt = 2'd0;
        @(negedge clock);
        resetN = 1;
        @(negedge clock);
    endtask

    task automatic startRun();
        checkCycle("idle", 3'd0, 1'b0);
        run = 1;
        @(negedge clock);
    endtask

    // One instruction from its first FETCH cycle through retire (or HALT)
    task automatic runInstr(input logic [31:0] instr, input int iWait, input int dWait,
                            input logic mRd, input logic mWr, input logic rWr,
                            input logic br, input logic ub, input logic zf,
                            input logic [31:0] off, input logic runAfter);
        logic taken;
        memReadFlag = mRd; memWriteFlag = mWr; regWriteFlag = rWr;
        branchFlag = br; unconditionalBranchFlag = ub; zeroFlag = zf;
        pcOffset = off; instrData = instr;
        for (int c = 0; c <= iWait; c++) begin
            checkCycle("fetch", 3'd1, 1'b0);
            instrReady = (c == iWait);
            @(negedge clock);
        end
        instrReady = 0;
        checkCycle("decode", 3'd2, 1'b0);
        checkVal("decode.ir", 64'(irOut), 64'(instr));
        checkVal("decode.pc", 64'(pcOut), 64'(modelPc));
        @(negedge clock);
        if (instr == HALT_OP) begin
            for (int c = 0; c < 3; c++) begin
                checkCycle("halt", 3'd6, 1'b0);
                checkVal("halt.pc", 64'(pcOut), 64'(modelPc));
                checkVal("halt.count", 64'(retiredCount), 64'(modelCnt));
                @(negedge clock);
            end
            return;
        end
        checkCycle("execute", 3'd3, 1'b0);
        run = runAfter;
        @(negedge clock);
        if (mRd || mWr) begin
            for (int c = 0; c <= dWait; c++) begin
                checkCycle("memory", 3'd4, mWr);
                dataReady = (c == dWait);
                @(negedge clock);
            end
            dataReady = 0;
        end
        if (rWr) begin
            checkCycle("writeback", 3'd5, 1'b0);
            @(negedge clock);
        end
        taken = ub | (br & zf);
        modelPc = modelPc + (taken ? off * 32'd4 : 32'd4);
        if (modelCnt != 2'd3) modelCnt = modelCnt + 2'd1;
        checkVal("retire.pc", 64'(pcOut), 64'(modelPc));
        checkVal("retire.count", 64'(retiredCount), 64'(modelCnt));
        checkCycle("retire", runAfter ? 3'd1 : 3'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] instr;
        logic [31:0] off;
        logic        runAfter;
        resetN = 0;
        run = 0;
        clearInputs();
        @(negedge clock);
        doReset();
        startRun();

        // ALU-only, load with 2 wait cycles, then step to 0x10
        runInstr(32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        runInstr(32'h0000_0002, 0, 2, 1, 0, 1, 0, 0, 0, 32'h0, 1);
        runInstr(32'h0000_0003, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        runInstr(32'h0000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        checkVal("pc.at10", 64'(pcOut), 64'h10);
        // Taken branch back by two words, then not-taken branch
        runInstr(32'h0000_0005, 1, 0, 0, 0, 0, 1, 0, 1, 32'hFFFF_FFFE, 1);
        checkVal("branch.taken", 64'(pcOut), 64'h08);
        runInstr(32'h0000_0006, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        runInstr(32'h0000_0007, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        runInstr(32'h0000_0008, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 1);
        checkVal("branch.nottaken", 64'(pcOut), 64'h14);
        // Store with run dropped mid-instruction ends in IDLE
        runInstr(32'h0000_0009, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clock);
        startRun();
        // PC wrap: jump to 0xFFFFFFFC then step
        runInstr(32'h0000_000A, 0, 0, 0, 0, 0, 0, 1, 0, (32'hFFFF_FFFC - modelPc) >> 2, 1);
        checkVal("pc.top", 64'(pcOut), 64'hFFFF_FFFC);
        runInstr(32'h0000_000B, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        checkVal("pc.wrap", 64'(pcOut), 64'h0);
        // Ready on the last permitted wait cycle of both handshakes
        runInstr(32'h0000_000C, 14, 14, 1, 0, 1, 0, 0, 0, 32'h0, 1);

        for (int n = 0; n < 30; n++) begin
            instr = $urandom;
            if (instr == HALT_OP) instr = 32'h0;
            off = 32'(int'($urandom_range(0, 63)) - 32);
            runAfter = ($urandom_range(0, 3) != 0);
            runInstr(instr, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                     off, runAfter);
            if (!runAfter) begin
                @(negedge clock);
                startRun();
            end
        end

        runInstr(HALT_OP, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);

        // Fetch timeout: ERROR after 15 unanswered FETCH cycles, sticky
        doReset();
        startRun();
        for (int c = 0; c < 15; c++) begin
            checkCycle("tofetch", 3'd1, 1'b0);
            @(negedge clock);
        end
        for (int c = 0; c < 4; c++) begin
            checkCycle("error", 3'd7, 1'b0);
            checkVal("error.pc", 64'(pcOut), 64'h0);
            @(negedge clock);
        end

        // Reset asserted mid-MEMORY drops dataReq asynchronously
        doReset();
        startRun();
        memWriteFlag = 1;
        instrData = 32'h0000_00AB;
        checkCycle("mr.fetch", 3'd1, 1'b0);
        instrReady = 1;
        @(negedge clock);
        instrReady = 0;
        checkCycle("mr.decode", 3'd2, 1'b0);
        @(negedge clock);
        checkCycle("mr.execute", 3'd3, 1'b0);
        @(negedge clock);
        checkCycle("mr.memory", 3'd4, 1'b1);
        doReset();
        checkCycle("mr.idle", 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
